// File: rtl/video_pkg.sv
// Shared video constants: default palette colours, default widths and the
// transparent palette index.
package video_pkg;

    localparam int DEF_INDEX_W     = 3;
    localparam int DEF_COLOR_W     = 4;
    localparam int TRANSPARENT_IDX = 0;

    // Colour bit order is {g2,b,g,r}
    localparam logic [3:0] COL_BLACK  = 4'b0000;
    localparam logic [3:0] COL_YELLOW = 4'b0011;
    localparam logic [3:0] COL_RED    = 4'b0001;
    localparam logic [3:0] COL_WHITE  = 4'b0111;
    localparam logic [3:0] COL_BLUE   = 4'b0100;
    localparam logic [3:0] COL_PINK   = 4'b1101;
    localparam logic [3:0] COL_CYAN   = 4'b0110;
    localparam logic [3:0] COL_ORANGE = 4'b1011;

    function automatic logic [3:0] default_color(input int unsigned idx);
        logic [3:0] c;
        case (idx)
            32'd0:   c = COL_BLACK;
            32'd1:   c = COL_YELLOW;
            32'd2:   c = COL_RED;
            32'd3:   c = COL_WHITE;
            32'd4:   c = COL_BLUE;
            32'd5:   c = COL_PINK;
            32'd6:   c = COL_CYAN;
            32'd7:   c = COL_ORANGE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Runtime-writable palette: register file with combinational read, reset to
// the default colours. A write lands one cycle after it is requested.
module palette_ram
    import video_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [INDEX_W-1:0] raddr,
    output logic [COLOR_W-1:0] rdata
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic [COLOR_W-1:0] mem_r [DEPTH];
    logic               wr_pend_r;
    logic [INDEX_W-1:0] wr_addr_r;
    logic [COLOR_W-1:0] wr_data_r;

    function automatic logic [COLOR_W-1:0] fit_color(input logic [3:0] c);
        logic [COLOR_W-1:0] r;
        r = '0;
        for (int b = 0; b < COLOR_W; b++) begin
            r[b] = (b < 4) ? c[b[1:0]] : 1'b0;
        end
        return r;
    endfunction

    // Holding the request aligns the commit with the palette-read stage of the
    // pixel presented alongside it, so that pixel still reads the old colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= fit_color(default_color(i));
            end
        end else begin
            wr_pend_r <= we;
            wr_addr_r <= waddr;
            wr_data_r <= wdata;
            if (wr_pend_r) begin
                mem_r[wr_addr_r] <= wr_data_r;
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/layer_compositor.sv
// Fixed-priority layer compositor with per-layer enable, frame-synchronous
// blinking, palette lookup over a two-stage pipeline and a sticky collision flag.
module layer_compositor
    import video_pkg::*;
#(
    parameter int NUM_LAYERS   = 3,
    parameter int INDEX_W      = DEF_INDEX_W,
    parameter int COLOR_W      = DEF_COLOR_W,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pix_valid,
    input  logic [NUM_LAYERS*INDEX_W-1:0]   layer_idx,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS-1:0]           blink_mask,
    input  logic                            frame_start,
    input  logic                            pal_we,
    input  logic [INDEX_W-1:0]              pal_addr,
    input  logic [COLOR_W-1:0]              pal_data,
    output logic [COLOR_W-1:0]              rgb,
    output logic                            rgb_valid,
    output logic [$clog2(NUM_LAYERS+1)-1:0] hit_layer,
    output logic                            overlap,
    output logic                            collision
);

    localparam int HIT_W = $clog2(NUM_LAYERS + 1);
    localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_LAYERS-1:0] vis_s;
    logic [INDEX_W-1:0]    win_idx_s;
    logic [HIT_W-1:0]      win_layer_s;
    logic                  overlap_s;
    logic [BCW-1:0]        blink_cnt_r;
    logic                  blink_phase_r;
    logic                  s1_valid_r;
    logic                  s1_overlap_r;
    logic [INDEX_W-1:0]    s1_idx_r;
    logic [HIT_W-1:0]      s1_hit_r;
    logic [COLOR_W-1:0]    pal_rdata_s;

    // Priority encode: scanning downwards leaves the lowest visible layer as winner.
    always_comb begin
        vis_s       = '0;
        win_idx_s   = INDEX_W'(TRANSPARENT_IDX);
        win_layer_s = HIT_W'(NUM_LAYERS);
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            vis_s[k] = layer_en[k]
                    && (layer_idx[k*INDEX_W +: INDEX_W] != INDEX_W'(TRANSPARENT_IDX))
                    && !(blink_mask[k] && blink_phase_r);
            win_idx_s   = vis_s[k] ? layer_idx[k*INDEX_W +: INDEX_W] : win_idx_s;
            win_layer_s = vis_s[k] ? HIT_W'(k) : win_layer_s;
        end
        overlap_s = |(vis_s & (vis_s - NUM_LAYERS'(1)));
    end

    // Blink counter advances per frame; phase flips on each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_r == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BCW'(1);
            end
        end
    end

    // Stage 1: winning index, layer and overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_overlap_r <= 1'b0;
            s1_idx_r     <= '0;
            s1_hit_r     <= '0;
        end else begin
            s1_valid_r <= pix_valid;
            if (pix_valid) begin
                s1_overlap_r <= overlap_s;
                s1_idx_r     <= win_idx_s;
                s1_hit_r     <= win_layer_s;
            end
        end
    end

    palette_ram #(
        .INDEX_W (INDEX_W),
        .COLOR_W (COLOR_W)
    ) u_palette (
        .clk   (clk),
        .reset (reset),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_data),
        .raddr (s1_idx_r),
        .rdata (pal_rdata_s)
    );

    // Stage 2: palette colour and outputs; non-valid slots hold the last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
            hit_layer <= '0;
            overlap   <= 1'b0;
        end else begin
            rgb_valid <= s1_valid_r;
            if (s1_valid_r) begin
                rgb       <= pal_rdata_s;
                hit_layer <= s1_hit_r;
                overlap   <= s1_overlap_r;
            end
        end
    end

    // An overlapping output pixel beats a same-cycle frame_start clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision <= 1'b0;
        end else begin
            collision <= (rgb_valid && overlap) || (collision && !frame_start);
        end
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised pixel compositor between the sprite/tile renderers and the VGA output stage. Each cycle it takes one palette index per layer, selects the highest-priority opaque layer, and looks up a runtime-writable palette. It registers the result over a fixed two-stage pipeline. Over generic fixed-priority mixing it adds per-layer enables, frame-synchronous blinking for selected layers, and a sticky per-frame overlap (collision) flag.

## Interface
Parameters:
- NUM_LAYERS, 3, number of input layers; layer 0 has highest priority (grid), then pacman, ghost, …
- INDEX_W, 3, palette index width; index 0 means transparent.
- COLOR_W, 4, output colour width, bit order {g2,b,g,r}.
- BLINK_FRAMES, 16, frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  the current layer_idx vector is a real pixel.
- layer_idx  in  NUM_LAYERS*INDEX_W  packed indices; layer k is bits [k*INDEX_W +: INDEX_W].
- layer_en  in  NUM_LAYERS  a layer with enable 0 is treated as transparent.
- blink_mask  in  NUM_LAYERS  layers subject to blinking.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- pal_we, pal_addr[INDEX_W], pal_data[COLOR_W]  in  palette write port.
- rgb  out  COLOR_W  composited colour.
- rgb_valid  out  1  rgb corresponds to a pix_valid two cycles earlier.
- hit_layer  out  clog2(NUM_LAYERS+1)  winning layer number; NUM_LAYERS means background.
- overlap  out  1  the current output pixel had ≥2 visible opaque layers.
- collision  out  1  sticky: overlap occurred since the last frame_start.

## Operation
- Visible(k) = layer_en[k] AND (layer_idx_k ≠ 0) AND NOT (blink_mask[k] AND blink_phase).
- Priority: the lowest k with Visible(k) wins. Its index goes to the palette, hit_layer=k.
- If no layer is visible, palette index 0 is used and hit_layer=NUM_LAYERS.
- Palette: 2^INDEX_W entries of COLOR_W bits.
- Palette reset contents for indices 0..7: 0000 black, 0011 yellow, 0010→0001 red, 0111 white, 0100 blue, 1101 pink, 0110 cyan, 1011 orange.
  - Exact mapping: idx0=0000, idx1=0011, idx2=0001, idx3=0111, idx4=0100, idx5=1101, idx6=0110, idx7=1011.
  - Entries above 7 reset to 0. For COLOR_W≠4, values are zero-extended or truncated at the MSB.
- Palette write: on pal_we, entry pal_addr takes pal_data at the clock edge. A same-cycle read of the same address returns the old value.
- Blink: a counter runs 0..BLINK_FRAMES-1 and advances on each frame_start. On wrap to 0, blink_phase toggles. Phase 0 means visible.
- Collision: set when overlap is produced with rgb_valid=1. Cleared on frame_start.
  - If a set and a clear fall in the same cycle, the set wins, so the flag belongs to the new frame.

## Timing
- Stage 1 registers the winning index, hit_layer, the overlap bit and a valid bit.
- Stage 2 performs the palette read and registers rgb, rgb_valid, hit_layer and overlap.
- Latency from pix_valid to rgb_valid is exactly 2 cycles. Throughput is one pixel per cycle with no stalls.
- The blink_phase change from frame_start applies to pixels presented from the next cycle onward.
- When pix_valid=0, rgb_valid=0 two cycles later. rgb, hit_layer and overlap hold their previous values.
- Reset values: rgb=0, rgb_valid=0, hit_layer=0, overlap=0, collision=0, blink counter=0, blink_phase=0. The palette is restored to its defaults.
- Reset mid-stream: both pipeline valid bits clear in the same edge. No partial pixel emerges afterwards.

## Structure
- Shared package/include `video_pkg` holds:
  - the default palette constants and colour names;
  - COLOR_W and INDEX_W defaults;
  - the transparent-index constant 0.
- Sub-module `palette_ram`: register file with a synchronous write, a combinational read and reset-to-default. The write-before-read ordering is handled inside it.
- The priority encoder and the blink/collision logic stay in the top module.

## Test plan
- Defaults, NUM_LAYERS=3, layer_en=111, idx={ghost=5, pacman=1, grid=0}, pix_valid pulse → two cycles later rgb=0011, hit_layer=1, overlap=1, rgb_valid=1.
- All idx 0 → rgb=0000, hit_layer=3, overlap=0. Then grid idx 4 with layer_en[0]=0 → the next layer wins, or background if none.
- Write pal_addr=1, pal_data=1111 in the same cycle as a pixel with idx1 → that pixel outputs 0011. The next pixel with idx1 outputs 1111.
- BLINK_FRAMES=2, blink_mask=001, grid idx 3:
  - after 2 frame_start pulses, the grid is hidden and the lower layer shows;
  - after 2 more pulses, the grid is visible again.
- Overlap pixel, then frame_start with no overlap → collision=1 until frame_start, then 0. An overlap pixel output in the same cycle as frame_start → collision stays 1.
- Assert reset with a pixel in each stage → rgb_valid=0 for the next 2 cycles, and the palette entry written earlier returns to its default.
